pipe_hit_checker: RTL

//  Consumes the four pipe X-edge pairs from the pipe position generator plus per-pipe gap tops and bird Y.

---
 rtl/pipe_hit_checker_pkg.sv | 30 +++
 rtl/pipe_hit_checker_overlap_cmp.sv | 36 +++
 rtl/pipe_hit_checker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hit_checker_pkg.sv
// Shared definitions for the pipe hit checker: FSM states, pipe count,
// default playfield geometry and a small widening helper.
package pipe_hit_checker_pkg;

  localparam int unsigned NUM_PIPES = 4;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned SUM_W     = COORD_W + 1;

  localparam int unsigned DEF_BIRD_X   = 200;
  localparam int unsigned DEF_BIRD_W   = 20;
  localparam int unsigned DEF_BIRD_H   = 20;
  localparam int unsigned DEF_GAP_H    = 120;
  localparam int unsigned DEF_SCREEN_H = 480;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PIPES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SCAN,
    ST_DONE,
    ST_HIT
  } state_e;

  // Zero-extend a screen coordinate so sums cannot wrap.
  function automatic logic [SUM_W-1:0] widen(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pipe_hit_checker_overlap_cmp.sv
// Combinational test of one pipe against the bird: overlap, pass and
// recycle (pipe back on the right of the bird) indications.
module pipe_hit_checker_overlap_cmp
  import pipe_hit_checker_pkg::*;
#(
  parameter int unsigned BIRD_X = DEF_BIRD_X,
  parameter int unsigned BIRD_W = DEF_BIRD_W,
  parameter int unsigned BIRD_H = DEF_BIRD_H,
  parameter int unsigned GAP_H  = DEF_GAP_H
) (
  input  logic [COORD_W-1:0] x_l_i,
  input  logic [COORD_W-1:0] x_r_i,
  input  logic [COORD_W-1:0] gap_top_i,
  input  logic [COORD_W-1:0] bird_y_i,
  input  logic               passed_i,
  output logic               overlap_o,
  output logic               pass_o,
  output logic               recycle_o
);

  logic [SUM_W-1:0] xl_w, xr_w, gt_w, by_w;
  logic             horiz, vert;

  assign xl_w = widen(x_l_i);
  assign xr_w = widen(x_r_i);
  assign gt_w = widen(gap_top_i);
  assign by_w = widen(bird_y_i);

  assign horiz = (xl_w < SUM_W'(BIRD_X + BIRD_W)) && (xr_w > SUM_W'(BIRD_X));
  assign vert  = (by_w < gt_w) || ((by_w + SUM_W'(BIRD_H)) > (gt_w + SUM_W'(GAP_H)));

  assign overlap_o = horiz && vert;
  assign pass_o    = (xr_w < SUM_W'(BIRD_X)) && !passed_i && !overlap_o;
  assign recycle_o = (xr_w >= SUM_W'(BIRD_X));

endmodule

// File: rtl/pipe_hit_checker.sv
// Per-frame collision / pass checker: snapshots bird and pipe geometry on
// a frame tick, scans the four pipes one per cycle, then checks the floor.
module pipe_hit_checker
  import pipe_hit_checker_pkg::*;
#(
  parameter int unsigned BIRD_X   = DEF_BIRD_X,
  parameter int unsigned BIRD_W   = DEF_BIRD_W,
  parameter int unsigned BIRD_H   = DEF_BIRD_H,
  parameter int unsigned GAP_H    = DEF_GAP_H,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               frame_tick,
  input  logic               Ack,
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] x_edge_0_l,
  input  logic [COORD_W-1:0] x_edge_0_r,
  input  logic [COORD_W-1:0] x_edge_1_l,
  input  logic [COORD_W-1:0] x_edge_1_r,
  input  logic [COORD_W-1:0] x_edge_2_l,
  input  logic [COORD_W-1:0] x_edge_2_r,
  input  logic [COORD_W-1:0] x_edge_3_l,
  input  logic [COORD_W-1:0] x_edge_3_r,
  input  logic [COORD_W-1:0] gap_top_0,
  input  logic [COORD_W-1:0] gap_top_1,
  input  logic [COORD_W-1:0] gap_top_2,
  input  logic [COORD_W-1:0] gap_top_3,
  output logic               hit,
  output logic               hit_floor,
  output logic [1:0]         hit_pipe,
  output logic               pass_pulse,
  output logic               check_done,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [NUM_PIPES-1:0] passed_q, passed_d;
  logic               hit_q, hit_d;
  logic               hit_floor_q, hit_floor_d;
  logic [1:0]         hit_pipe_q, hit_pipe_d;

  logic [COORD_W-1:0] xl_in [NUM_PIPES];
  logic [COORD_W-1:0] xr_in [NUM_PIPES];
  logic [COORD_W-1:0] gt_in [NUM_PIPES];
  logic [COORD_W-1:0] xl_q  [NUM_PIPES];
  logic [COORD_W-1:0] xr_q  [NUM_PIPES];
  logic [COORD_W-1:0] gt_q  [NUM_PIPES];
  logic [COORD_W-1:0] by_q;

  logic cmp_overlap, cmp_pass, cmp_recycle, floor_now;

  assign xl_in[0] = x_edge_0_l;  assign xr_in[0] = x_edge_0_r;  assign gt_in[0] = gap_top_0;
  assign xl_in[1] = x_edge_1_l;  assign xr_in[1] = x_edge_1_r;  assign gt_in[1] = gap_top_1;
  assign xl_in[2] = x_edge_2_l;  assign xr_in[2] = x_edge_2_r;  assign gt_in[2] = gap_top_2;
  assign xl_in[3] = x_edge_3_l;  assign xr_in[3] = x_edge_3_r;  assign gt_in[3] = gap_top_3;

  pipe_hit_checker_overlap_cmp #(
    .BIRD_X (BIRD_X),
    .BIRD_W (BIRD_W),
    .BIRD_H (BIRD_H),
    .GAP_H  (GAP_H)
  ) u_cmp (
    .x_l_i     (xl_q[idx_q]),
    .x_r_i     (xr_q[idx_q]),
    .gap_top_i (gt_q[idx_q]),
    .bird_y_i  (by_q),
    .passed_i  (passed_q[idx_q]),
    .overlap_o (cmp_overlap),
    .pass_o    (cmp_pass),
    .recycle_o (cmp_recycle)
  );

  assign floor_now = (widen(by_q) + SUM_W'(BIRD_H)) >= SUM_W'(SCREEN_H);

  // Snapshot of bird and pipe geometry, captured during SNAP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      by_q <= '0;
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        xl_q[i] <= '0;
        xr_q[i] <= '0;
        gt_q[i] <= '0;
      end
    end else if (state_q == ST_SNAP) begin
      by_q <= bird_y;
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        xl_q[i] <= xl_in[i];
        xr_q[i] <= xr_in[i];
        gt_q[i] <= gt_in[i];
      end
    end
  end

  // FSM state, scan index, passed flags and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      passed_q    <= '0;
      hit_q       <= 1'b0;
      hit_floor_q <= 1'b0;
      hit_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      passed_q    <= passed_d;
      hit_q       <= hit_d;
      hit_floor_q <= hit_floor_d;
      hit_pipe_q  <= hit_pipe_d;
    end
  end

  // Next-state logic, per-pipe scan decisions and pulse outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    passed_d    = passed_q;
    hit_d       = hit_q;
    hit_floor_d = hit_floor_q;
    hit_pipe_d  = hit_pipe_q;
    pass_pulse  = 1'b0;
    check_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick && run) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        idx_d   = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (cmp_overlap && !hit_q) begin
          hit_d      = 1'b1;
          hit_pipe_d = idx_q;
        end
        if (cmp_pass) begin
          pass_pulse       = 1'b1;
          passed_d[idx_q]  = 1'b1;
        end else if (cmp_recycle) begin
          passed_d[idx_q]  = 1'b0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          // Floor result is registered on the last scan cycle so that it is
          // already visible alongside check_done in DONE.
          if (floor_now && !hit_q && !cmp_overlap) begin
            hit_d       = 1'b1;
            hit_floor_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_DONE: begin
        check_done = 1'b1;
        state_d    = hit_q ? ST_HIT : ST_IDLE;
      end
      ST_HIT: begin
        if (Ack) begin
          state_d     = ST_IDLE;
          hit_d       = 1'b0;
          hit_floor_d = 1'b0;
          hit_pipe_d  = '0;
          passed_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hit       = hit_q;
  assign hit_floor = hit_floor_q;
  assign hit_pipe  = hit_pipe_q;
  assign busy      = (state_q == ST_SNAP) || (state_q == ST_SCAN) || (state_q == ST_DONE);

endmodule
